// File: rtl/noc_pkg.sv
// Shared NOC definitions: flit width/type and pointer wrap helper.
package noc_pkg;

  localparam int unsigned FLIT_W = 16;

  typedef logic [FLIT_W-1:0] flit_t;

  // Advance a circular-buffer pointer, wrapping explicitly so depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/noc_ibuf_mem.sv
// Flit storage for the input buffer: DEPTH x FLIT_W array, one write port,
// one asynchronous read port. The data array is deliberately not reset.
module noc_ibuf_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [FLIT_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [FLIT_W-1:0] rdata
);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];

  // Next array contents: copy current, overwrite the written slot.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Array register, no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/noc_input_buffer.sv
// Receive-side NOC input buffer: link enable/data into a DEPTH-entry circular
// FIFO, valid/ready toward the router core, one credit pulse per freed slot.
// Optional sticky overflow flag `err` is built when NOC_IBUF_ERR_EN is defined.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLIT_W = noc_pkg::FLIT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [FLIT_W-1:0]          data,
  output logic                       credit,
  output logic                       out_valid,
  output logic [FLIT_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef NOC_IBUF_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          credit_q, credit_d;
  logic          full, deq, enq;

  // A full buffer still accepts a flit when the head leaves in the same cycle.
  assign out_valid = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign deq       = out_valid & out_ready;
  assign enq       = enable & (~full | deq);
  assign count     = cnt_q;
  assign credit    = credit_q;

  noc_ibuf_mem #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wp_q),
    .wdata (data),
    .raddr (rp_q),
    .rdata (out_data)
  );

  // Next pointers, occupancy and credit from this cycle's enqueue/dequeue.
  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    cnt_d    = cnt_q;
    credit_d = deq;
    if (enq) wp_d = AW'(ptr_inc(32'(wp_q), DEPTH));
    if (deq) rp_d = AW'(ptr_inc(32'(rp_q), DEPTH));
    if (enq && !deq)      cnt_d = cnt_q + CW'(1);
    else if (deq && !enq) cnt_d = cnt_q - CW'(1);
  end

  // Control registers; reset discards stored flits and any pending credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      credit_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
    end
  end

`ifdef NOC_IBUF_ERR_EN
  logic err_q, err_d;

  // Sticky overflow: a flit arrived while full with nothing leaving.
  always_comb begin
    err_d = err_q | (enable & full & ~deq);
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
